// File: rtl/bitpack_pkg.sv
// Shared state encoding, LFSR feedback masks and seed table for the
// stochastic bitstream sequencer.
package bitpack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned MAX_W = 16;

  localparam logic [7:0] SEED_TABLE [4] = '{8'hA5, 8'h3C, 8'h71, 8'hE2};

  // Fibonacci feedback mask: bit k set means stage k+1 of the polynomial is tapped.
  function automatic logic [MAX_W-1:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return 16'h000C;
      8:       return 16'h00B8;
      16:      return 16'hB400;
      default: return 16'h00B8;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] sng_seed(input int unsigned idx);
    if (idx < 4) return {8'h00, SEED_TABLE[idx[1:0]]};
    return MAX_W'(idx + 1);
  endfunction

endpackage

// File: rtl/bit_sng.sv
// Stochastic number generator: maximal-length Fibonacci LFSR whose state is
// compared against X to produce one stream bit per cycle.
module bit_sng
  import bitpack_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic             EN,
  input  logic [WIDTH-1:0] X,
  output logic             BIT
);

  localparam logic [MAX_W-1:0] TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (LOAD) begin
      lfsr_d = SEED;
    end else if (EN) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  // The LFSR never holds zero, so X=0 yields no ones and X=all-ones yields all ones.
  assign BIT = (lfsr_q <= X);

endmodule

// File: rtl/bit_stream_ctrl.sv
// Sequencer for a 4-input stochastic bitstream core: issues LEN SNG bits to the
// core, counts ones on its PROD/AVG outputs, and reports via START/BUSY/DONE.
module bit_stream_ctrl
  import bitpack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned LEN_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic [LEN_W-1:0]        LEN,
  input  logic [N_IN*WIDTH-1:0]   X,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [LEN_W-1:0]        CNT_PROD,
  output logic [LEN_W-1:0]        CNT_AVG,
  output logic [N_IN-1:0]         CORE_A,
  output logic [$clog2(N_IN)-1:0] CORE_SEL,
  input  logic                    CORE_PROD,
  input  logic                    CORE_AVG
);

  localparam int unsigned SEL_W = $clog2(N_IN);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [N_IN*WIDTH-1:0]   x_q, x_d;
  logic [LEN_W-1:0]        issue_q, issue_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    valid_q, valid_d;
  logic [LEN_W-1:0]        cnt_prod_q, cnt_prod_d;
  logic [LEN_W-1:0]        cnt_avg_q, cnt_avg_d;
  logic [N_IN-1:0]         core_a_q, core_a_d;
  logic [SEL_W-1:0]        core_sel_q, core_sel_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    sng_load, sng_en;
  logic [N_IN-1:0]         sng_bit;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_sng
    localparam logic [MAX_W-1:0] SEED_FULL = sng_seed(gi);
    bit_sng #(
      .WIDTH (WIDTH),
      .SEED  (SEED_FULL[WIDTH-1:0])
    ) u_sng (
      .CLK   (CLK),
      .RST_N (RST_N),
      .LOAD  (sng_load),
      .EN    (sng_en),
      .X     (x_q[gi*WIDTH +: WIDTH]),
      .BIT   (sng_bit[gi])
    );
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    x_d        = x_q;
    issue_d    = issue_q;
    sel_d      = sel_q;
    valid_d    = 1'b0;
    cnt_prod_d = cnt_prod_q;
    cnt_avg_d  = cnt_avg_q;
    core_a_d   = '0;
    core_sel_d = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sng_load   = 1'b0;
    sng_en     = 1'b0;

    // The core output for the bit issued last cycle is counted on this edge.
    if (valid_q) begin
      cnt_prod_d = cnt_prod_q + LEN_W'(CORE_PROD);
      cnt_avg_d  = cnt_avg_q  + LEN_W'(CORE_AVG);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          len_d      = LEN;
          x_d        = X;
          sng_load   = 1'b1;
          cnt_prod_d = '0;
          cnt_avg_d  = '0;
          issue_d    = '0;
          sel_d      = '0;
          busy_d     = 1'b1;
          state_d    = (LEN == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        sng_en     = 1'b1;
        valid_d    = 1'b1;
        core_a_d   = sng_bit;
        core_sel_d = sel_q;
        sel_d      = sel_q + SEL_W'(1);
        issue_d    = issue_q + LEN_W'(1);
        if (issue_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      x_q        <= '0;
      issue_q    <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      cnt_prod_q <= '0;
      cnt_avg_q  <= '0;
      core_a_q   <= '0;
      core_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      x_q        <= x_d;
      issue_q    <= issue_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      cnt_prod_q <= cnt_prod_d;
      cnt_avg_q  <= cnt_avg_d;
      core_a_q   <= core_a_d;
      core_sel_q <= core_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CNT_PROD = cnt_prod_q;
  assign CNT_AVG  = cnt_avg_q;
  assign CORE_A   = core_a_q;
  assign CORE_SEL = core_sel_q;

endmodule

// File: tb/tb_bit_stream_ctrl.sv
// Bench for bit_stream_ctrl: models the core as PROD=&A, AVG=A[SEL] and predicts
// counts from the LFSR orbit table and each input's seed position.
module tb_bit_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic [31:0] x;
  logic        busy, done;
  logic [15:0] cnt_prod, cnt_avg;
  logic [3:0]  core_a;
  logic [1:0]  core_sel;
  logic        core_prod, core_avg;

  int checks = 0;
  int errors = 0;

  int unsigned orbit [255];

  bit_stream_ctrl #(
    .WIDTH (8),
    .N_IN  (4),
    .LEN_W (16)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .LEN       (len),
    .X         (x),
    .BUSY      (busy),
    .DONE      (done),
    .CNT_PROD  (cnt_prod),
    .CNT_AVG   (cnt_avg),
    .CORE_A    (core_a),
    .CORE_SEL  (core_sel),
    .CORE_PROD (core_prod),
    .CORE_AVG  (core_avg)
  );

  assign core_prod = &core_a;
  assign core_avg  = core_a[core_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Orbit of x^8+x^6+x^5+x^4+1 starting at 1; every nonzero byte appears once.
  function automatic void build_orbit();
    logic [7:0] s;
    s = 8'd1;
    for (int k = 0; k < 255; k++) begin
      orbit[k] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endfunction

  function automatic void model(input logic [31:0] xw, input int unsigned ln,
                                output int unsigned prod, output int unsigned avg);
    logic [7:0]  seeds [4];
    int unsigned pos [4];
    logic [3:0]  a;
    seeds = '{8'hA5, 8'h3C, 8'h71, 8'hE2};
    for (int i = 0; i < 4; i++) begin
      pos[i] = 0;
      for (int k = 0; k < 255; k++) if (orbit[k] == seeds[i]) pos[i] = k;
    end
    prod = 0;
    avg  = 0;
    for (int unsigned k = 0; k < ln; k++) begin
      for (int i = 0; i < 4; i++) a[i] = (orbit[(pos[i] + k) % 255] <= xw[i*8 +: 8]);
      if (&a) prod++;
      if (a[k % 4]) avg++;
    end
  endfunction

  // Stimulus only: runs one transaction and reports what was observed.
  task automatic do_run(input logic [31:0] xw, input int unsigned ln, input int poke_cyc,
                        output int done_cyc, output logic [15:0] cp, output logic [15:0] ca,
                        output int n_done, output int busy_err, output int a_stray);
    int  bound;
    logic exp_busy;
    done_cyc = -1; cp = '0; ca = '0; n_done = 0; busy_err = 0; a_stray = 0;
    bound = int'(ln) + 12;
    @(negedge clk);
    x = xw; len = 16'(ln); start = 1'b1;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; cp = cnt_prod; ca = cnt_avg;
        end
      end
      exp_busy = (done_cyc < 0) || (cyc == done_cyc);
      if (busy !== exp_busy) busy_err++;
      if ((cyc == 1 || cyc >= int'(ln) + 2) && (core_a !== 4'd0 || core_sel !== 2'd0)) a_stray++;
      if (poke_cyc > 0 && cyc == poke_cyc) begin
        start = 1'b1; x = ~xw; len = 16'(ln + 5);
      end else if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; x = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cnt_prod, cnt_avg, core_a, core_sel} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b prod=%0d avg=%0d a=%h sel=%0d, expected all 0",
               busy, done, cnt_prod, cnt_avg, core_a, core_sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_all_ones();
    int dc, nd, be, as; logic [15:0] cp, ca;
    do_run(32'hFFFF_FFFF, 100, 0, dc, cp, ca, nd, be, as);
    checks++; if (dc !== 102) begin errors++; $display("FAIL ones_latency: got %0d expected 102", dc); end
    checks++; if (cp !== 16'd100) begin errors++; $display("FAIL ones_prod: got %0d expected 100", cp); end
    checks++; if (ca !== 16'd100) begin errors++; $display("FAIL ones_avg: got %0d expected 100", ca); end
    checks++; if (nd !== 1 || be !== 0 || as !== 0) begin
      errors++; $display("FAIL ones_handshake: got dones=%0d busy_err=%0d stray=%0d expected 1 0 0", nd, be, as);
    end
  endtask

  task automatic test_alternating();
    int dc, nd, be, as; logic [15:0] cp, ca;
    do_run({8'd0, 8'd255, 8'd0, 8'd255}, 255, 0, dc, cp, ca, nd, be, as);
    checks++; if (cp !== 16'd0) begin errors++; $display("FAIL alt_prod: got %0d expected 0", cp); end
    checks++; if (ca !== 16'd128) begin errors++; $display("FAIL alt_avg: got %0d expected 128", ca); end
    checks++; if (dc !== 257) begin errors++; $display("FAIL alt_latency: got %0d expected 257", dc); end
  endtask

  task automatic test_exactness();
    int dc, nd, be, as; logic [15:0] cp, ca, cp2, ca2; logic [7:0] r;
    do_run({8'd255, 8'd255, 8'd255, 8'd128}, 255, 0, dc, cp, ca, nd, be, as);
    checks++; if (cp !== 16'd128) begin errors++; $display("FAIL exact_prod128: got %0d expected 128", cp); end
    do_run({8'd255, 8'd255, 8'd255, 8'd128}, 255, 0, dc, cp2, ca2, nd, be, as);
    checks++; if (cp2 !== cp || ca2 !== ca) begin
      errors++; $display("FAIL exact_repeat: got %0d/%0d expected %0d/%0d", cp2, ca2, cp, ca);
    end
    r = 8'($urandom);
    do_run({8'd255, 8'd255, 8'd255, r}, 255, 0, dc, cp, ca, nd, be, as);
    checks++; if (cp !== 16'(r)) begin errors++; $display("FAIL exact_prod_rand: got %0d expected %0d", cp, r); end
  endtask

  task automatic test_len_zero();
    int dc, nd, be, as; logic [15:0] cp, ca;
    do_run(32'hFFFF_FFFF, 0, 0, dc, cp, ca, nd, be, as);
    checks++; if (dc !== 2) begin errors++; $display("FAIL len0_latency: got %0d expected 2", dc); end
    checks++; if (cp !== 16'd0 || ca !== 16'd0) begin
      errors++; $display("FAIL len0_counts: got %0d/%0d expected 0/0", cp, ca);
    end
    checks++; if (as !== 0 || be !== 0 || nd !== 1) begin
      errors++; $display("FAIL len0_core_idle: got stray=%0d busy_err=%0d dones=%0d expected 0 0 1", as, be, nd);
    end
  endtask

  task automatic test_random();
    int dc, nd, be, as; logic [15:0] cp, ca; logic [31:0] xw;
    int unsigned ln, ep, ea;
    for (int n = 0; n < 6; n++) begin
      xw = $urandom;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 4))
          0: xw[i*8 +: 8] = 8'd0;
          1: xw[i*8 +: 8] = 8'd255;
          default: ;
        endcase
      end
      ln = $urandom_range(1, 300);
      model(xw, ln, ep, ea);
      do_run(xw, ln, 0, dc, cp, ca, nd, be, as);
      checks++; if (cp !== 16'(ep) || ca !== 16'(ea)) begin
        errors++; $display("FAIL rand_counts[%0d]: x=%h len=%0d got %0d/%0d expected %0d/%0d",
                           n, xw, ln, cp, ca, ep, ea);
      end
      checks++; if (dc !== int'(ln) + 2 || nd !== 1 || be !== 0 || as !== 0) begin
        errors++; $display("FAIL rand_timing[%0d]: got done_cyc=%0d dones=%0d busy_err=%0d stray=%0d expected %0d 1 0 0",
                           n, dc, nd, be, as, ln + 2);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd, be, as; logic [15:0] cp, ca; logic [31:0] xw;
    int unsigned ep, ea;
    int pokes [3];
    pokes = '{6, 21, 22};
    xw = $urandom;
    model(xw, 20, ep, ea);
    for (int p = 0; p < 3; p++) begin
      do_run(xw, 20, pokes[p], dc, cp, ca, nd, be, as);
      checks++; if (cp !== 16'(ep) || ca !== 16'(ea) || dc !== 22 || nd !== 1 || be !== 0) begin
        errors++; $display("FAIL start_ignored[poke %0d]: got %0d/%0d done_cyc=%0d dones=%0d busy_err=%0d expected %0d/%0d 22 1 0",
                           pokes[p], cp, ca, dc, nd, be, ep, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, second, nd; logic [15:0] cp1, ca1, cp2, ca2; logic [31:0] xw;
    int unsigned ep, ea;
    xw = $urandom;
    model(xw, 7, ep, ea);
    first = -1; second = -1; nd = 0; cp1 = '0; ca1 = '0; cp2 = '0; ca2 = '0;
    @(negedge clk);
    x = xw; len = 16'd7; start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin
          first = cyc; cp1 = cnt_prod; ca1 = cnt_avg;
        end else if (second < 0) begin
          second = cyc; cp2 = cnt_prod; ca2 = cnt_avg; start = 1'b0;
        end
      end
      if (second >= 0 && cyc >= second + 4) break;
    end
    start = 1'b0;
    checks++; if (first !== 9 || second !== 19 || nd !== 2) begin
      errors++; $display("FAIL b2b_timing: got first=%0d second=%0d dones=%0d expected 9 19 2", first, second, nd);
    end
    checks++; if (cp1 !== 16'(ep) || ca1 !== 16'(ea) || cp2 !== 16'(ep) || ca2 !== 16'(ea)) begin
      errors++; $display("FAIL b2b_counts: got %0d/%0d and %0d/%0d expected %0d/%0d",
                         cp1, ca1, cp2, ca2, ep, ea);
    end
  endtask

  task automatic test_count_hold();
    int dc, nd, be, as, got; logic [15:0] cp, ca; logic [31:0] xw;
    int unsigned ep, ea, ep3, ea3;
    xw = $urandom;
    model(xw, 40, ep, ea);
    model(xw, 3, ep3, ea3);
    do_run(xw, 40, 0, dc, cp, ca, nd, be, as);
    repeat (5) @(negedge clk);
    checks++; if (cnt_prod !== 16'(ep) || cnt_avg !== 16'(ea)) begin
      errors++; $display("FAIL hold_counts: got %0d/%0d expected %0d/%0d", cnt_prod, cnt_avg, ep, ea);
    end
    x = xw; len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (cnt_prod !== 16'd0 || cnt_avg !== 16'd0) begin
      errors++; $display("FAIL clear_on_start: got %0d/%0d expected 0/0", cnt_prod, cnt_avg);
    end
    got = -1;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done && got < 0) begin
        got = cyc; cp = cnt_prod; ca = cnt_avg;
      end
    end
    checks++; if (got !== 5 || cp !== 16'(ep3) || ca !== 16'(ea3)) begin
      errors++; $display("FAIL short_run: got done_cyc=%0d %0d/%0d expected 5 %0d/%0d", got, cp, ca, ep3, ea3);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, nd, be, as, seen; logic [15:0] cp, ca; logic [31:0] xw;
    int unsigned ep, ea;
    @(negedge clk);
    x = 32'hFFFF_FFFF; len = 16'd50; start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    checks++; if (cnt_prod !== 16'd8) begin
      errors++; $display("FAIL midrun_progress: got %0d expected 8", cnt_prod);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cnt_prod, cnt_avg, core_a, core_sel} !== 40'd0) begin
      errors++; $display("FAIL async_reset: got busy=%0b done=%0b prod=%0d avg=%0d a=%h sel=%0d expected all 0",
                         busy, done, cnt_prod, cnt_avg, core_a, core_sel);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL no_done_after_abort: got %0d busy/done cycles expected 0", seen);
    end
    xw = $urandom;
    model(xw, 50, ep, ea);
    do_run(xw, 50, 0, dc, cp, ca, nd, be, as);
    checks++; if (cp !== 16'(ep) || ca !== 16'(ea) || dc !== 52) begin
      errors++; $display("FAIL fresh_after_reset: got %0d/%0d done_cyc=%0d expected %0d/%0d 52",
                         cp, ca, dc, ep, ea);
    end
  endtask

  initial begin
    build_orbit();
    test_reset();
    test_all_ones();
    test_alternating();
    test_exactness();
    test_len_zero();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_count_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
